// File: rtl/reorder_buffer_if.sv
// Handshake bundle between rename/issue/commit and the reorder buffer.
// The ROB_FLUSH_EN flush input is a plain port on reorder_buffer, not part of this bundle.
interface reorder_buffer_if #(
  parameter int AREG_W = 5,
  parameter int PREG_W = 6,
  parameter int IDX_W  = 4
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [AREG_W-1:0] alloc_rd;
  logic [PREG_W-1:0] alloc_pd;
  logic [PREG_W-1:0] alloc_old_pd;
  logic              alloc_regwrite;
  logic              alloc_store;
  logic [IDX_W-1:0]  alloc_idx;

  logic              cmpl_valid;
  logic [IDX_W-1:0]  cmpl_idx;
  logic [31:0]       cmpl_result;

  logic              retire_valid;
  logic              retire_ready;
  logic [AREG_W-1:0] retire_rd;
  logic [PREG_W-1:0] retire_pd;
  logic [PREG_W-1:0] retire_old_pd;
  logic [31:0]       retire_result;
  logic              retire_regwrite;
  logic              retire_store;
  logic              empty;

  modport master (
    output alloc_valid, alloc_rd, alloc_pd, alloc_old_pd, alloc_regwrite, alloc_store,
    output cmpl_valid, cmpl_idx, cmpl_result,
    output retire_ready,
    input  alloc_ready, alloc_idx,
    input  retire_valid, retire_rd, retire_pd, retire_old_pd, retire_result,
    input  retire_regwrite, retire_store, empty
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_pd, alloc_old_pd, alloc_regwrite, alloc_store,
    input  cmpl_valid, cmpl_idx, cmpl_result,
    input  retire_ready,
    output alloc_ready, alloc_idx,
    output retire_valid, retire_rd, retire_pd, retire_old_pd, retire_result,
    output retire_regwrite, retire_store, empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at tail, records out-of-order completions, retires from head.
// Optional ROB_FLUSH_EN adds a flush input that empties the buffer at the next clock edge.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int AREG_W = 5,
  parameter int PREG_W = 6,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input logic clk,
  input logic rstn,
`ifdef ROB_FLUSH_EN
  input logic flush,
`endif
  reorder_buffer_if.slave bus
);

  localparam logic [IDX_W:0]   FullCount = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CountOne  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IdxOne    = IDX_W'(1);

  logic [DEPTH-1:0]  validQ;
  logic [DEPTH-1:0]  doneQ;
  logic [DEPTH-1:0]  regwriteQ;
  logic [DEPTH-1:0]  storeQ;
  logic [AREG_W-1:0] rdQ     [DEPTH];
  logic [PREG_W-1:0] pdQ     [DEPTH];
  logic [PREG_W-1:0] oldPdQ  [DEPTH];
  logic [31:0]       resultQ [DEPTH];

  logic [IDX_W-1:0]  headQ;
  logic [IDX_W-1:0]  tailQ;
  logic [IDX_W:0]    countQ;

  logic isEmpty;
  logic allocReady;
  logic allocFire;
  logic retireValid;
  logic retireFire;
  logic cmplHit;

  assign isEmpty     = (countQ == '0);
  assign allocReady  = (countQ != FullCount);
  assign allocFire   = bus.alloc_valid && allocReady;
  assign retireValid = !isEmpty && doneQ[headQ];
  assign retireFire  = retireValid && bus.retire_ready;
  assign cmplHit     = bus.cmpl_valid && validQ[bus.cmpl_idx];

  // Retire clears after completion so a same-cycle completion cannot resurrect a retiring entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      validQ <= '0;
      doneQ  <= '0;
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end
`ifdef ROB_FLUSH_EN
    else if (flush) begin
      validQ <= '0;
      doneQ  <= '0;
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end
`endif
    else begin
      if (cmplHit) begin
        doneQ[bus.cmpl_idx] <= 1'b1;
      end
      if (allocFire) begin
        validQ[tailQ] <= 1'b1;
        doneQ[tailQ]  <= 1'b0;
        tailQ         <= tailQ + IdxOne;
      end
      if (retireFire) begin
        validQ[headQ] <= 1'b0;
        doneQ[headQ]  <= 1'b0;
        headQ         <= headQ + IdxOne;
      end
      case ({allocFire, retireFire})
        2'b10:   countQ <= countQ + CountOne;
        2'b01:   countQ <= countQ - CountOne;
        default: countQ <= countQ;
      endcase
    end
  end

  // Payload storage needs no reset: valid/done gate every use of it.
  always_ff @(posedge clk) begin
    if (allocFire) begin
      rdQ[tailQ]       <= bus.alloc_rd;
      pdQ[tailQ]       <= bus.alloc_pd;
      oldPdQ[tailQ]    <= bus.alloc_old_pd;
      regwriteQ[tailQ] <= bus.alloc_regwrite;
      storeQ[tailQ]    <= bus.alloc_store;
    end
    if (cmplHit) begin
      resultQ[bus.cmpl_idx] <= bus.cmpl_result;
    end
  end

  assign bus.alloc_ready = allocReady;
  assign bus.alloc_idx   = tailQ;
  assign bus.empty       = isEmpty;
  assign bus.retire_valid = retireValid;

  // Head fields are forced to zero unless the head is actually committing.
  assign bus.retire_rd       = retireValid ? rdQ[headQ]       : '0;
  assign bus.retire_pd       = retireValid ? pdQ[headQ]       : '0;
  assign bus.retire_old_pd   = retireValid ? oldPdQ[headQ]    : '0;
  assign bus.retire_result   = retireValid ? resultQ[headQ]   : '0;
  assign bus.retire_regwrite = retireValid ? regwriteQ[headQ] : 1'b0;
  assign bus.retire_store    = retireValid ? storeQ[headQ]    : 1'b0;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued at allocation and checked by a monitor.
// Flush coverage is compiled in only when ROB_FLUSH_EN is defined.
module tb_reorder_buffer;

  typedef struct packed {
    logic [4:0]  rd;
    logic [5:0]  pd;
    logic [5:0]  oldPd;
    logic        regwrite;
    logic        store;
    logic [31:0] result;
  } robExp_t;

  logic clk;
  logic rstn;
`ifdef ROB_FLUSH_EN
  logic flush;
`endif

  robExp_t     expQ[$];
  logic [31:0] planned [16];
  int          checkCount;
  int          passCount;

  reorder_buffer_if #(.AREG_W(5), .PREG_W(6), .IDX_W(4)) rob ();

  reorder_buffer #(.DEPTH(16), .AREG_W(5), .PREG_W(6)) dut (
    .clk  (clk),
    .rstn (rstn),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .bus  (rob)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Advance one clock with the staged inputs, then drop the single-cycle strobes.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    rob.alloc_valid = 1'b0;
    rob.cmpl_valid  = 1'b0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic setAlloc(input logic [4:0] rd, input logic [5:0] pd, input logic [5:0] oldPd,
                          input logic rw, input logic st, input logic [31:0] result,
                          input logic [31:0] expIdx, input bit push);
    robExp_t e;
    checkOutput("allocIdx", 32'(rob.alloc_idx), expIdx);
    rob.alloc_valid    = 1'b1;
    rob.alloc_rd       = rd;
    rob.alloc_pd       = pd;
    rob.alloc_old_pd   = oldPd;
    rob.alloc_regwrite = rw;
    rob.alloc_store    = st;
    if (push) begin
      e.rd = rd; e.pd = pd; e.oldPd = oldPd; e.regwrite = rw; e.store = st; e.result = result;
      expQ.push_back(e);
      planned[expIdx[3:0]] = result;
    end
  endtask

  task automatic setCmpl(input logic [3:0] idx, input logic [31:0] value);
    rob.cmpl_valid  = 1'b1;
    rob.cmpl_idx    = idx;
    rob.cmpl_result = value;
  endtask

  task automatic setCmplPlanned(input logic [3:0] idx);
    setCmpl(idx, planned[idx]);
  endtask

  // Every accepted retirement must match the oldest outstanding allocation.
  always @(negedge clk) begin : monitor
    robExp_t e;
    if (rstn && rob.retire_valid && rob.retire_ready) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedRetire: got rd %0d expected no retirement", rob.retire_rd);
      end else begin
        e = expQ.pop_front();
        checkOutput("retireRd",       32'(rob.retire_rd),       32'(e.rd));
        checkOutput("retirePd",       32'(rob.retire_pd),       32'(e.pd));
        checkOutput("retireOldPd",    32'(rob.retire_old_pd),   32'(e.oldPd));
        checkOutput("retireRegwrite", 32'(rob.retire_regwrite), 32'(e.regwrite));
        checkOutput("retireStore",    32'(rob.retire_store),    32'(e.store));
        checkOutput("retireResult",   rob.retire_result,        e.result);
      end
    end
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    rob.alloc_valid = 1'b0; rob.alloc_rd = '0; rob.alloc_pd = '0; rob.alloc_old_pd = '0;
    rob.alloc_regwrite = 1'b0; rob.alloc_store = 1'b0;
    rob.cmpl_valid = 1'b0; rob.cmpl_idx = '0; rob.cmpl_result = '0;
    rob.retire_ready = 1'b0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
    rstn = 1'b1;
    #2 rstn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("resetAllocReady",   32'(rob.alloc_ready),  32'd1);
    checkOutput("resetAllocIdx",     32'(rob.alloc_idx),    32'd0);
    checkOutput("resetRetireValid",  32'(rob.retire_valid), 32'd0);
    checkOutput("resetEmpty",        32'(rob.empty),        32'd1);
    checkOutput("resetRetireRd",     32'(rob.retire_rd),    32'd0);
    checkOutput("resetRetireResult", rob.retire_result,     32'd0);
    #2 rstn = 1'b1;

    // Basic allocate, complete head, hold then release retire_ready.
    setAlloc(5'd1, 6'd33, 6'd1, 1'b1, 1'b0, 32'hA5, 32'd0, 1'b1); applyStimulus();
    setAlloc(5'd2, 6'd34, 6'd2, 1'b1, 1'b0, 32'h22, 32'd1, 1'b1); applyStimulus();
    setAlloc(5'd3, 6'd35, 6'd3, 1'b0, 1'b1, 32'h33, 32'd2, 1'b1); applyStimulus();
    checkOutput("notEmpty",        32'(rob.empty),        32'd0);
    checkOutput("noRetireYet",     32'(rob.retire_valid), 32'd0);
    setCmplPlanned(4'd0); applyStimulus();
    checkOutput("headDoneValid",   32'(rob.retire_valid), 32'd1);
    checkOutput("headRd",          32'(rob.retire_rd),    32'd1);
    checkOutput("headPd",          32'(rob.retire_pd),    32'd33);
    checkOutput("headResult",      rob.retire_result,     32'hA5);
    applyStimulus(); applyStimulus();
    checkOutput("holdValid",       32'(rob.retire_valid), 32'd1);
    checkOutput("holdPd",          32'(rob.retire_pd),    32'd33);
    rob.retire_ready = 1'b1;
    applyStimulus();
    checkOutput("headAdvanced",    32'(rob.retire_valid), 32'd0);

    // Out-of-order completion including a result overwrite.
    setCmpl(4'd2, 32'hBAD); applyStimulus();
    checkOutput("oooWait1",        32'(rob.retire_valid), 32'd0);
    setCmplPlanned(4'd2); applyStimulus();
    checkOutput("oooWait2",        32'(rob.retire_valid), 32'd0);
    setCmplPlanned(4'd1); applyStimulus();
    checkOutput("oooRetire1",      32'(rob.retire_rd),    32'd2);
    applyStimulus();
    checkOutput("overwriteResult", rob.retire_result,     32'h33);
    applyStimulus();
    checkOutput("drainedEmpty",    32'(rob.empty),        32'd1);

    setAlloc(5'd4, 6'd36, 6'd4, 1'b1, 1'b0, 32'h3C, 32'd3, 1'b1); applyStimulus();
    setAlloc(5'd5, 6'd37, 6'd5, 1'b1, 1'b0, 32'h44, 32'd4, 1'b1); applyStimulus();
    setAlloc(5'd6, 6'd38, 6'd6, 1'b1, 1'b1, 32'h55, 32'd5, 1'b1); applyStimulus();
    setCmplPlanned(4'd5); applyStimulus();
    setCmplPlanned(4'd4); applyStimulus();
    checkOutput("oooBlocked",      32'(rob.retire_valid), 32'd0);
    setCmplPlanned(4'd3); applyStimulus();
    checkOutput("burstRd0",        32'(rob.retire_rd),    32'd4);
    applyStimulus();
    checkOutput("burstRd1",        32'(rob.retire_rd),    32'd5);
    applyStimulus();
    checkOutput("burstRd2",        32'(rob.retire_rd),    32'd6);
    applyStimulus();
    checkOutput("burstEmpty",      32'(rob.empty),        32'd1);

    // Asynchronous reset with five live entries.
    rob.retire_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      setAlloc(5'(i + 7), 6'(i + 40), 6'(i + 7), 1'b1, 1'b0, 32'h600 + 32'(i), 32'(i + 6), 1'b1);
      applyStimulus();
    end
    setCmplPlanned(4'd6); applyStimulus();
    checkOutput("preResetValid",   32'(rob.retire_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("asyncEmpty",      32'(rob.empty),        32'd1);
    checkOutput("asyncRetireValid",32'(rob.retire_valid), 32'd0);
    checkOutput("asyncAllocIdx",   32'(rob.alloc_idx),    32'd0);
    checkOutput("asyncAllocReady", 32'(rob.alloc_ready),  32'd1);
    checkOutput("asyncRetireRd",   32'(rob.retire_rd),    32'd0);
    expQ.delete();
    #3 rstn = 1'b1;

    // Fill all sixteen entries, try a seventeenth, retire one while full.
    for (int i = 0; i < 16; i++) begin
      setAlloc(5'(i + 1), 6'(i + 20), 6'(i), i[0], ((i % 4) == 0), 32'h1000 + 32'(i), 32'(i), 1'b1);
      applyStimulus();
    end
    checkOutput("fullNotReady",    32'(rob.alloc_ready),  32'd0);
    checkOutput("fullNotEmpty",    32'(rob.empty),        32'd0);
    setAlloc(5'd31, 6'd63, 6'd63, 1'b1, 1'b1, 32'hFFFF, 32'd0, 1'b0); applyStimulus();
    checkOutput("ignoredAllocIdx", 32'(rob.alloc_idx),    32'd0);
    checkOutput("stillFull",       32'(rob.alloc_ready),  32'd0);
    setCmplPlanned(4'd0); applyStimulus();
    checkOutput("fullHeadValid",   32'(rob.retire_valid), 32'd1);
    rob.retire_ready = 1'b1;
    setAlloc(5'd30, 6'd62, 6'd62, 1'b0, 1'b0, 32'hEEEE, 32'd0, 1'b0); applyStimulus();
    rob.retire_ready = 1'b0;
    checkOutput("noFullBypassIdx", 32'(rob.alloc_idx),    32'd0);
    checkOutput("readyAfterRetire",32'(rob.alloc_ready),  32'd1);
    setAlloc(5'd17, 6'd50, 6'd16, 1'b1, 1'b0, 32'h2000, 32'd0, 1'b1); applyStimulus();
    checkOutput("refilledFull",    32'(rob.alloc_ready),  32'd0);

    rob.retire_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      setCmplPlanned(4'(k));
      applyStimulus();
    end
    setCmplPlanned(4'd0); applyStimulus();
    applyStimulus(); applyStimulus();
    checkOutput("fullDrainEmpty",  32'(rob.empty),        32'd1);
    checkOutput("fullDrainTail",   32'(rob.alloc_idx),    32'd1);

    // Allocate and retire in the same cycle: occupancy holds, both pointers move.
    setAlloc(5'd9, 6'd41, 6'd9, 1'b1, 1'b0, 32'h7001, 32'd1, 1'b1); applyStimulus();
    setCmplPlanned(4'd1); applyStimulus();
    setAlloc(5'd10, 6'd42, 6'd10, 1'b0, 1'b1, 32'h7002, 32'd2, 1'b1); applyStimulus();
    checkOutput("simulNotEmpty",   32'(rob.empty),        32'd0);
    checkOutput("simulNoRetire",   32'(rob.retire_valid), 32'd0);
    checkOutput("simulTail",       32'(rob.alloc_idx),    32'd3);
    setCmplPlanned(4'd2); applyStimulus();
    applyStimulus();
    checkOutput("simulDrained",    32'(rob.empty),        32'd1);

`ifdef ROB_FLUSH_EN
    // Flush wins over a coincident allocate and completion.
    rob.retire_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setAlloc(5'(i + 12), 6'(i + 44), 6'(i), 1'b1, 1'b0, 32'h800 + 32'(i), 32'(i + 3), 1'b1);
      applyStimulus();
    end
    setAlloc(5'd20, 6'd48, 6'd20, 1'b1, 1'b0, 32'h900, 32'd7, 1'b1);
    setCmplPlanned(4'd3);
    flush = 1'b1;
    applyStimulus();
    checkOutput("flushEmpty",      32'(rob.empty),        32'd1);
    checkOutput("flushAllocIdx",   32'(rob.alloc_idx),    32'd0);
    checkOutput("flushRetire",     32'(rob.retire_valid), 32'd0);
    checkOutput("flushReady",      32'(rob.alloc_ready),  32'd1);
    expQ.delete();
    applyStimulus();
    checkOutput("flushNoLateRetire", 32'(rob.retire_valid), 32'd0);
`endif

    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer (ROB) that sits directly downstream of the rename stage. It accepts one renamed instruction per cycle and returns a ROB index that travels with the instruction into issue. It records out-of-order completions and retires at most one instruction per cycle in program order. Retiring an instruction publishes its architectural commit and the stale physical register to be freed back to rename.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥4
- AREG_W, 5, architectural register index width
- PREG_W, 6, physical register index width
- IDX_W, $clog2(DEPTH), ROB index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset; asynchronous, active-low
- alloc_valid  in  1  renamed instruction presented
- alloc_ready  out  1  ROB can accept (count < DEPTH)
- alloc_rd  in  AREG_W  architectural destination
- alloc_pd  in  PREG_W  new physical destination
- alloc_old_pd  in  PREG_W  previous mapping of alloc_rd
- alloc_regwrite  in  1  instruction writes a register
- alloc_store  in  1  instruction is a store
- alloc_idx  out  IDX_W  index assigned (current tail)
- cmpl_valid  in  1  functional unit completion
- cmpl_idx  in  IDX_W  completing entry
- cmpl_result  in  32  result value
- retire_valid  out  1  head entry done, committing
- retire_ready  in  1  commit consumer accepts
- retire_rd / retire_pd / retire_old_pd  out  AREG_W/PREG_W/PREG_W  head entry fields
- retire_result  out  32  head result
- retire_regwrite / retire_store  out  1/1  head flags
- empty  out  1  count == 0
- flush  in  1  present only with ROB_FLUSH_EN

## Operation
- Per-entry state: valid, done, rd, pd, old_pd, regwrite, store, result[31:0].
- Head pointer, tail pointer: IDX_W bits each, wrap modulo DEPTH. Occupancy count: IDX_W+1 bits.
- Allocate: when alloc_valid && alloc_ready, write the entry at tail with valid=1 and done=0, then increment tail. alloc_idx always equals tail.
- Complete: when cmpl_valid and entry[cmpl_idx].valid, set done=1 and store result. A completion to an invalid entry is ignored. A completion to an already-done entry overwrites result.
- Retire: retire_valid = !empty && entry[head].done. All retire_* outputs are combinational from the head entry. When retire_valid && retire_ready, clear valid and done, then increment head.
- Simultaneous allocate and retire: count is unchanged and both pointers advance.
- Full: alloc_ready=0 even if a retire fires in the same cycle; no full-bypass. alloc_valid is ignored while alloc_ready=0.
- Completion and retire of the same head entry in one cycle: retire uses the pre-edge done bit, so that entry is not retired in that cycle.
- Wrap-around: tail==head with count==DEPTH means full; with count==0 it means empty.
- Reset or mid-operation reset: all valid and done bits, head, tail and count clear immediately. Outputs: alloc_ready=1, alloc_idx=0, retire_valid=0, empty=1, retire_* data 0.

## Timing
- Allocation is visible one cycle later: an entry written at edge N can complete at edge N+1 at the earliest.
- Completion sampled at edge N makes retire_valid high during cycle N+1 if that entry is the head.
- Minimum allocate-to-retire latency is 2 cycles.
- Throughput: 1 allocate, 1 complete, 1 retire per cycle.
- retire_valid may drop only by retire or reset, never spontaneously.

## Configuration
- ROB_FLUSH_EN defined: adds the flush input. flush sampled high at an edge clears all valid and done bits, head, tail and count; it takes priority over allocate, complete and retire in that cycle. retire_valid=0 and alloc_idx=0 in the following cycle.
- ROB_FLUSH_EN undefined: no flush port; the entry pool is cleared only by rstn.

## Test plan
- Reset, then allocate 3 entries (rd=1,2,3; pd=33,34,35) → alloc_idx 0,1,2; complete idx 0 with 0xA5 → next cycle retire_valid=1, retire_rd=1, retire_pd=33, retire_result=0xA5.
- Out-of-order: complete idx 2 then idx 1 → no retire until idx 0 completes; then retires 0,1,2 on consecutive cycles with retire_ready=1.
- Fill 16 entries → alloc_ready=0; a 17th alloc_valid is ignored; retire one → alloc_ready=1 next cycle; next alloc_idx=0 (wrap).
- Hold retire_ready=0 with a done head → retire_valid stays 1 and outputs stay stable; raise retire_ready → head advances by 1.
- Assert rstn low mid-stream with 5 entries valid → empty=1, retire_valid=0, alloc_idx=0 asynchronously.
- ROB_FLUSH_EN: 4 entries valid, flush pulse coincident with alloc and cmpl → next cycle empty=1, alloc_idx=0, no retire.
